branch_predictor: RTL and testbench

Fetch-side dynamic branch predictor and next-PC source selector for the 5-stage RV32I pipeline. Each cycle it looks up the fetch PC in a direct-mapped BTB with 2-bit saturating counters and predicts a redirect. It also checks the execute-stage resolution of branches and jumps. It drives the 3-bit `PCSrc` code that selects the PC mux and feeds the flush unit immediately downstream.

---
 rtl/bp_pkg.sv | 38 +++
 rtl/bp_btb.sv | 37 +++
 rtl/branch_predictor.sv | 125 ++++++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// BTB entries hold the tag and target in 30-bit fields, enough for any
// XLEN up to 32 and any index width.
package bp_pkg;

    localparam int BP_ADDR_W = 30;

    typedef enum logic [2:0] {
        PCSRC_SEQ   = 3'b000,
        PCSRC_PRED  = 3'b001,
        PCSRC_BR    = 3'b010,
        PCSRC_JALR  = 3'b011,
        PCSRC_RECOV = 3'b101
    } pcsrc_t;

    typedef struct packed {
        logic                 valid;
        logic [BP_ADDR_W-1:0] tag;
        logic [BP_ADDR_W-1:0] target;
        logic [1:0]           ctr;
    } btb_entry_t;

    localparam logic [1:0] CTR_RESET    = 2'b01;
    localparam logic [1:0] CTR_ALLOC_BR = 2'b10;
    localparam logic [1:0] CTR_JAL      = 2'b11;

    // Two-bit saturating counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11)
            res = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            res = ctr - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// E-stage update read) and one registered write port with synchronous clear.
module bp_btb
    import bp_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_f,
    output btb_entry_t       rd_entry_f,
    input  logic [IDX_W-1:0] rd_idx_e,
    output btb_entry_t       rd_entry_e,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    localparam int DEPTH = 1 << IDX_W;

    btb_entry_t mem [DEPTH];

    assign rd_entry_f = mem[rd_idx_f];
    assign rd_entry_e = mem[rd_idx_e];

    // Storage write; reset invalidates every entry and returns ctr to weakly not-taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor and next-PC select for the RV32I pipeline.
// Optional macro BP_PERF_CNT_EN enables the branch/mispredict counters;
// when undefined the counter ports are tied to zero.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    input  logic            BranchE,
    input  logic            JalE,
    input  logic            JalrE,
    input  logic            TakenE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [2:0]      PCSrc,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    output logic [XLEN-1:0] RecoverPC,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MispredCnt
);

    logic [IDX_W-1:0]     idx_f, idx_e;
    logic [BP_ADDR_W-1:0] tag_f, tag_e, tgt_e;
    btb_entry_t           ent_f, ent_e, wr_entry;
    logic                 wr_en, hit_f, hit_e;
    logic                 taken_mis, nt_mis;
    pcsrc_t               pcsrc;

    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_f = BP_ADDR_W'(PCF >> (IDX_W + 2));
    assign tag_e = BP_ADDR_W'(PCE >> (IDX_W + 2));
    assign tgt_e = BP_ADDR_W'(PCTargetE[XLEN-1:2]);

    bp_btb #(.IDX_W(IDX_W)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_f   (idx_f),
        .rd_entry_f (ent_f),
        .rd_idx_e   (idx_e),
        .rd_entry_e (ent_e),
        .wr_en      (wr_en),
        .wr_idx     (idx_e),
        .wr_entry   (wr_entry)
    );

    assign hit_f = ent_f.valid && (ent_f.tag == tag_f);
    assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

    assign PredTakenF  = rst_n && hit_f && ent_f.ctr[1];
    assign PredTargetF = (rst_n && hit_f) ? XLEN'({ent_f.target, 2'b00}) : '0;
    assign RecoverPC   = PCE + XLEN'(4);

    assign taken_mis = ((BranchE && TakenE) || JalE) &&
                       (!PredTakenE || (PredTargetE != PCTargetE));
    assign nt_mis    = BranchE && !TakenE && PredTakenE;

    // Next-PC select: E-stage corrections outrank the fetch prediction.
    always_comb begin
        pcsrc = PCSRC_SEQ;
        if (!rst_n)
            pcsrc = PCSRC_SEQ;
        else if (JalrE)
            pcsrc = PCSRC_JALR;
        else if (taken_mis)
            pcsrc = PCSRC_BR;
        else if (nt_mis)
            pcsrc = PCSRC_RECOV;
        else if (PredTakenF)
            pcsrc = PCSRC_PRED;
    end

    assign PCSrc = pcsrc;

    // BTB update from the resolved E-stage branch or JAL; JALR never trains.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ent_e;
        if (BranchE) begin
            if (hit_e) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_step(ent_e.ctr, TakenE);
                if (TakenE)
                    wr_entry.target = tgt_e;
            end else if (TakenE) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: tag_e, target: tgt_e, ctr: CTR_ALLOC_BR};
            end
        end else if (JalE) begin
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: tag_e, target: tgt_e, ctr: CTR_JAL};
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] branch_cnt, mispred_cnt;

    // Performance counters: resolved branches/JALs and PC corrections.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (BranchE || JalE)
                branch_cnt <= branch_cnt + 32'd1;
            if (pcsrc == PCSRC_BR || pcsrc == PCSRC_JALR || pcsrc == PCSRC_RECOV)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign BranchCnt  = branch_cnt;
    assign MispredCnt = mispred_cnt;
`else
    assign BranchCnt  = '0;
    assign MispredCnt = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_W=6, XLEN=32).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, PredTargetE, PCE, PCTargetE;
    logic        BranchE, JalE, JalrE, TakenE, PredTakenE;
    logic [2:0]  PCSrc;
    logic        PredTakenF;
    logic [31:0] PredTargetF, RecoverPC, BranchCnt, MispredCnt;

    int tests = 0;
    int fails = 0;

    branch_predictor #(.IDX_W(6), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .BranchE     (BranchE),
        .JalE        (JalE),
        .JalrE       (JalrE),
        .TakenE      (TakenE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .PCE         (PCE),
        .PCTargetE   (PCTargetE),
        .PCSrc       (PCSrc),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .RecoverPC   (RecoverPC),
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
    );

    always #5 clk = ~clk;

`ifdef BP_PERF_CNT_EN
    localparam logic [31:0] EXP_BR_LOOP  = 32'd10;
    localparam logic [31:0] EXP_MIS_LOOP = 32'd2;
`else
    localparam logic [31:0] EXP_BR_LOOP  = 32'd0;
    localparam logic [31:0] EXP_MIS_LOOP = 32'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_e();
        BranchE = 0; JalE = 0; JalrE = 0; TakenE = 0; PredTakenE = 0;
        PredTargetE = 0; PCTargetE = 0; PCE = 32'h300;
    endtask

    task automatic set_e(input logic br, input logic jal, input logic jalr, input logic tk,
                         input logic ptk, input logic [31:0] pc, input logic [31:0] ptgt,
                         input logic [31:0] tgt);
        BranchE = br; JalE = jal; JalrE = jalr; TakenE = tk; PredTakenE = ptk;
        PCE = pc; PredTargetE = ptgt; PCTargetE = tgt;
    endtask

    task automatic test_reset();
        rst_n = 0; PCF = 32'h100; idle_e(); JalrE = 1;
        #2;
        tests++; if (PCSrc !== 3'b000) begin fails++; $display("FAIL rst_force_pcsrc got %b exp 000", PCSrc); end
        tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0) begin fails++; $display("FAIL rst_force_pred got %b/%h exp 0/0", PredTakenF, PredTargetF); end
        tick(); tick();
        rst_n = 1; idle_e(); PCF = 32'h100; PCE = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PCSrc !== 3'b000) begin fails++; $display("FAIL post_rst_lookup got %b/%b exp 0/000", PredTakenF, PCSrc); end
        tests++; if (RecoverPC !== 32'h104) begin fails++; $display("FAIL recover_pc got %h exp 104", RecoverPC); end
        tests++; if (BranchCnt !== 32'h0 || MispredCnt !== 32'h0) begin fails++; $display("FAIL rst_counters got %0d/%0d exp 0/0", BranchCnt, MispredCnt); end
    endtask

    task automatic test_alloc_predict();
        PCF = 32'h100; set_e(1, 0, 0, 1, 0, 32'h100, 32'h0, 32'h80);
        #1;
        tests++; if (PCSrc !== 3'b010) begin fails++; $display("FAIL alloc_pcsrc got %b exp 010", PCSrc); end
        tests++; if (PredTakenF !== 1'b0) begin fails++; $display("FAIL same_cycle_pre_update got %b exp 0", PredTakenF); end
        tick(); idle_e(); PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80 || PCSrc !== 3'b001) begin fails++; $display("FAIL alloc_lookup got %b/%h/%b exp 1/80/001", PredTakenF, PredTargetF, PCSrc); end
        PCF = 32'h104;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PCSrc !== 3'b000) begin fails++; $display("FAIL neighbour_miss got %b/%b exp 0/000", PredTakenF, PCSrc); end
    endtask

    task automatic test_loop_exit();
        PCF = 32'h300; set_e(1, 0, 0, 0, 1, 32'h100, 32'h80, 32'h80);
        #1;
        tests++; if (PCSrc !== 3'b101 || RecoverPC !== 32'h104) begin fails++; $display("FAIL loop_exit got %b/%h exp 101/104", PCSrc, RecoverPC); end
        tick(); idle_e(); PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h80 || PCSrc !== 3'b000) begin fails++; $display("FAIL exit_lookup got %b/%h/%b exp 0/80/000", PredTakenF, PredTargetF, PCSrc); end
    endtask

    task automatic test_saturation();
        PCF = 32'h300;
        set_e(1, 0, 0, 0, 0, 32'h100, 32'h0, 32'h80);   // 01 -> 00
        #1;
        tests++; if (PCSrc !== 3'b000) begin fails++; $display("FAIL nt_correct_pcsrc got %b exp 000", PCSrc); end
        tick();                                          // 00 stays 00
        tick();
        set_e(1, 0, 0, 1, 0, 32'h100, 32'h0, 32'h80);   // 00 -> 01
        #1;
        tests++; if (PCSrc !== 3'b010) begin fails++; $display("FAIL sat_lo_taken_pcsrc got %b exp 010", PCSrc); end
        tick(); idle_e(); PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b0) begin fails++; $display("FAIL sat_low got %b exp 0", PredTakenF); end
        PCF = 32'h300;
        set_e(1, 0, 0, 1, 0, 32'h100, 32'h0, 32'h80);   // 01 -> 10
        tick();
        set_e(1, 0, 0, 1, 1, 32'h100, 32'h80, 32'h80);  // 10 -> 11
        #1;
        tests++; if (PCSrc !== 3'b000) begin fails++; $display("FAIL correct_taken_pcsrc got %b exp 000", PCSrc); end
        tick();                                          // 11 stays 11
        tick();
        set_e(1, 0, 0, 0, 1, 32'h100, 32'h80, 32'h80);  // 11 -> 10
        tick(); idle_e(); PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b1) begin fails++; $display("FAIL sat_high got %b exp 1", PredTakenF); end
    endtask

    task automatic test_jalr();
        PCF = 32'h100; set_e(0, 0, 1, 0, 1, 32'h400, 32'h80, 32'h80);
        #1;
        tests++; if (PCSrc !== 3'b011) begin fails++; $display("FAIL jalr_pcsrc got %b exp 011", PCSrc); end
        tick(); idle_e(); PCF = 32'h400;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0) begin fails++; $display("FAIL jalr_no_alloc got %b/%h exp 0/0", PredTakenF, PredTargetF); end
        PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin fails++; $display("FAIL jalr_btb_kept got %b/%h exp 1/80", PredTakenF, PredTargetF); end
    endtask

    task automatic test_override();
        PCF = 32'h100; set_e(1, 0, 0, 1, 1, 32'h100, 32'h80, 32'h90);
        #1;
        tests++; if (PCSrc !== 3'b010) begin fails++; $display("FAIL override_pcsrc got %b exp 010", PCSrc); end
        tick(); idle_e(); PCF = 32'h100;
        #1;
        tests++; if (PredTargetF !== 32'h90 || PCSrc !== 3'b001) begin fails++; $display("FAIL target_update got %h/%b exp 90/001", PredTargetF, PCSrc); end
    endtask

    task automatic test_jal_alias();
        PCF = 32'h300; set_e(0, 1, 0, 0, 0, 32'h200, 32'h0, 32'h40);
        #1;
        tests++; if (PCSrc !== 3'b010) begin fails++; $display("FAIL jal_pcsrc got %b exp 010", PCSrc); end
        tick(); idle_e(); PCF = 32'h200;
        #1;
        tests++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h40) begin fails++; $display("FAIL jal_lookup got %b/%h exp 1/40", PredTakenF, PredTargetF); end
        PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0) begin fails++; $display("FAIL alias_evict got %b/%h exp 0/0", PredTakenF, PredTargetF); end
        PCF = 32'h300; set_e(1, 0, 0, 0, 0, 32'h200, 32'h0, 32'h40);   // 11 -> 10
        tick(); idle_e(); PCF = 32'h200;
        #1;
        tests++; if (PredTakenF !== 1'b1) begin fails++; $display("FAIL jal_ctr_strong got %b exp 1", PredTakenF); end
        PCF = 32'h300; set_e(0, 1, 0, 0, 1, 32'h200, 32'h40, 32'h40);
        #1;
        tests++; if (PCSrc !== 3'b000) begin fails++; $display("FAIL jal_correct_pcsrc got %b exp 000", PCSrc); end
        tick(); idle_e();
    endtask

    task automatic test_reset_mid();
        rst_n = 0; PCF = 32'h200;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0 || PCSrc !== 3'b000) begin fails++; $display("FAIL mid_rst_force got %b/%h/%b exp 0/0/000", PredTakenF, PredTargetF, PCSrc); end
        tick();
        rst_n = 1;
        #1;
        tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0) begin fails++; $display("FAIL mid_rst_clear got %b/%h exp 0/0", PredTakenF, PredTargetF); end
        PCF = 32'h100;
        #1;
        tests++; if (PredTakenF !== 1'b0) begin fails++; $display("FAIL mid_rst_clear2 got %b exp 0", PredTakenF); end
    endtask

    task automatic test_perf_loop();
        logic [2:0] exp_src;
        PCF = 32'h300;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                set_e(1, 0, 0, 1, 0, 32'h100, 32'h0, 32'h80);  exp_src = 3'b010;
            end else if (i < 9) begin
                set_e(1, 0, 0, 1, 1, 32'h100, 32'h80, 32'h80); exp_src = 3'b000;
            end else begin
                set_e(1, 0, 0, 0, 1, 32'h100, 32'h80, 32'h80); exp_src = 3'b101;
            end
            #1;
            tests++; if (PCSrc !== exp_src) begin fails++; $display("FAIL loop_pcsrc iter %0d got %b exp %b", i, PCSrc, exp_src); end
            tick();
        end
        idle_e();
        #1;
        tests++; if (BranchCnt !== EXP_BR_LOOP) begin fails++; $display("FAIL branch_cnt got %0d exp %0d", BranchCnt, EXP_BR_LOOP); end
        tests++; if (MispredCnt !== EXP_MIS_LOOP) begin fails++; $display("FAIL mispred_cnt got %0d exp %0d", MispredCnt, EXP_MIS_LOOP); end
    endtask

    initial begin
        rst_n = 0; PCF = 0; idle_e();
        test_reset();
        test_alloc_predict();
        test_loop_exit();
        test_saturation();
        test_jalr();
        test_override();
        test_jal_alias();
        test_reset_mid();
        test_perf_loop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
